// File: rtl/fetch_stage_pkg.sv
// fetch_pkg: shared definitions for the instruction-fetch stage.
//   fetch_state_t : request FSM states
//   DEF_RESET_PC  : default PC after reset
//   PC_INC        : sequential fetch stride in bytes
package fetch_pkg;

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,  // request outstanding to imem
    S_HOLD  = 2'd1,  // response captured in skid, waiting on freeze release
    S_DRAIN = 2'd2   // discarding a response made stale by a branch
  } fetch_state_t;

  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
  localparam int          PC_INC       = 4;

endpackage

// File: rtl/fetch_stage_if.sv
// fetch_stage_if: instruction-memory request/response bus.
//   req   : request valid (fetch -> mem)
//   addr  : request address (fetch -> mem)
//   rdata : instruction data (mem -> fetch), valid with ready
//   ready : one-cycle completion pulse (mem -> fetch)
interface fetch_stage_if #(
  parameter int ADDR_W  = 32,
  parameter int INSTR_W = 32
);
  logic               req;
  logic [ADDR_W-1:0]  addr;
  logic [INSTR_W-1:0] rdata;
  logic               ready;

  modport master (output req, addr, input rdata, ready);
  modport slave  (input req, addr, output rdata, ready);
endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// if_id_reg: IF/ID pipeline register {pc, instr, valid}.
//   load   : capture d_pc/d_instr, mark valid
//   bubble : clear valid, keep pc/instr
//   flush  : clear valid (wins over load)
//   rst    : synchronous, active-high, clears everything
module if_id_reg #(
  parameter int ADDR_W  = 32,
  parameter int INSTR_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               bubble,
  input  logic               flush,
  input  logic [ADDR_W-1:0]  d_pc,
  input  logic [INSTR_W-1:0] d_instr,
  output logic [ADDR_W-1:0]  pc,
  output logic [INSTR_W-1:0] instr,
  output logic               valid
);

  always_ff @(posedge clk) begin
    if (rst) begin
      pc    <= '0;
      instr <= '0;
      valid <= 1'b0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      pc    <= d_pc;
      instr <= d_instr;
      valid <= 1'b1;
    end else if (bubble) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: owns the PC, issues requests to a variable-latency imem and
// loads IF/ID. A one-entry skid holds a response that arrives during freeze.
//   clk, rst        : clock, synchronous active-high reset
//   freeze          : hazard stall, holds PC and IF/ID
//   branch_taken    : EXE redirect, flushes IF/ID (beats freeze)
//   branch_addr     : redirect target
//   imem            : memory bus (master side)
//   id_pc/id_instr  : IF/ID contents, id_pc is PC+4 of the instruction
//   id_valid        : IF/ID holds a real instruction
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                INSTR_W  = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               freeze,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_addr,
  fetch_stage_if.master      imem,
  output logic [ADDR_W-1:0]  id_pc,
  output logic [INSTR_W-1:0] id_instr,
  output logic               id_valid
);

  localparam logic [ADDR_W-1:0] INC = ADDR_W'(PC_INC);

  fetch_state_t       state, nstate;
  logic [ADDR_W-1:0]  pc, pc_plus;
  logic [INSTR_W-1:0] skid, ld_instr;
  logic               ld, bub, fl, pc_inc, skid_cap;

  // wraps mod 2^ADDR_W naturally
  assign pc_plus = pc + INC;

  // request decoded from registered state/PC only
  assign imem.req  = (state == S_REQ);
  assign imem.addr = pc;

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= S_REQ;
    else     state <= nstate;
  end

  // next state
  always_comb begin
    nstate = state;
    case (state)
      S_REQ: begin
        if (branch_taken)             nstate = imem.ready ? S_REQ : S_DRAIN;
        else if (imem.ready && freeze) nstate = S_HOLD;
      end
      S_HOLD: begin
        if (branch_taken || !freeze) nstate = S_REQ;
      end
      S_DRAIN: begin
        // the stale request still has to complete, even across a new branch
        if (imem.ready) nstate = S_REQ;
      end
      default: nstate = S_REQ;
    endcase
  end

  // datapath controls
  always_comb begin
    ld       = 1'b0;
    bub      = 1'b0;
    fl       = 1'b0;
    pc_inc   = 1'b0;
    skid_cap = 1'b0;
    ld_instr = imem.rdata;
    case (state)
      S_REQ: begin
        if (branch_taken) fl = 1'b1;
        else if (imem.ready && !freeze) begin
          ld     = 1'b1;
          pc_inc = 1'b1;
        end
        else if (imem.ready) skid_cap = 1'b1;
        else if (!freeze)    bub      = 1'b1;
      end
      S_HOLD: begin
        if (branch_taken) fl = 1'b1;
        else if (!freeze) begin
          ld       = 1'b1;
          ld_instr = skid;
          pc_inc   = 1'b1;
        end
      end
      S_DRAIN: begin
        if (branch_taken) fl = 1'b1;
      end
      default: ;
    endcase
  end

  // PC: branch overrides everything, otherwise advance on consume
  always_ff @(posedge clk) begin
    if (rst)               pc <= RESET_PC;
    else if (branch_taken) pc <= branch_addr;
    else if (pc_inc)       pc <= pc_plus;
  end

  // skid contents only matter in S_HOLD; leaving that state empties it
  always_ff @(posedge clk) begin
    if (rst)           skid <= '0;
    else if (skid_cap) skid <= imem.rdata;
  end

  if_id_reg #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) u_if_id (
    .clk     (clk),
    .rst     (rst),
    .load    (ld),
    .bubble  (bub),
    .flush   (fl),
    .d_pc    (pc_plus),
    .d_instr (ld_instr),
    .pc      (id_pc),
    .instr   (id_instr),
    .valid   (id_valid)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage. Memory data is addr ^ E000_0000; ready is
// driven per step by the stimulus.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        freeze;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
  logic        id_valid;
  int          total = 0;
  int          bad   = 0;

  fetch_stage_if #(.ADDR_W(32), .INSTR_W(32)) bus ();

  fetch_stage #(.ADDR_W(32), .INSTR_W(32), .RESET_PC(32'h0)) dut (
    .clk          (clk),
    .rst          (rst),
    .freeze       (freeze),
    .branch_taken (branch_taken),
    .branch_addr  (branch_addr),
    .imem         (bus),
    .id_pc        (id_pc),
    .id_instr     (id_instr),
    .id_valid     (id_valid)
  );

  always #5 clk = ~clk;

  assign bus.rdata = bus.addr ^ 32'hE000_0000;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_id(input string tag, input logic [31:0] pc, input logic [31:0] ins);
    chk({tag, "_valid"}, {31'd0, id_valid}, 32'd1);
    chk({tag, "_pc"}, id_pc, pc);
    chk({tag, "_instr"}, id_instr, ins);
  endtask

  initial begin
    rst = 1'b1; freeze = 1'b0; branch_taken = 1'b0; branch_addr = '0;
    bus.ready = 1'b0;

    // reset
    tick();
    chk("rst_valid0", {31'd0, id_valid}, 32'd0);
    tick();
    chk("rst_valid1", {31'd0, id_valid}, 32'd0);
    chk("rst_pc", id_pc, 32'h0);
    chk("rst_instr", id_instr, 32'h0);
    rst = 1'b0;
    chk("rst_req", {31'd0, bus.req}, 32'd1);
    chk("rst_addr", bus.addr, 32'h0);

    // zero-wait stream
    bus.ready = 1'b1;
    tick(); chk_id("s0", 32'd4, 32'hE000_0000);
    tick(); chk_id("s1", 32'd8, 32'hE000_0004);

    // freeze with capture at PC=8
    freeze = 1'b1;
    tick(); chk_id("frz0", 32'd8, 32'hE000_0004);
    chk("frz_req", {31'd0, bus.req}, 32'd0);
    tick(); chk_id("frz1", 32'd8, 32'hE000_0004);
    tick(); chk_id("frz2", 32'd8, 32'hE000_0004);
    freeze = 1'b0;
    tick(); chk_id("rel", 32'd12, 32'hE000_0008);
    chk("rel_req", {31'd0, bus.req}, 32'd1);
    chk("rel_addr", bus.addr, 32'd12);
    tick(); chk_id("rel_next", 32'd16, 32'hE000_000C);

    // latency-3 memory, two rounds
    for (int r = 0; r < 2; r++) begin
      bus.ready = 1'b0;
      tick(); chk("lat_v0", {31'd0, id_valid}, 32'd0);
      chk("lat_addr0", bus.addr, 32'd16 + 32'(r * 4));
      tick(); chk("lat_v1", {31'd0, id_valid}, 32'd0);
      chk("lat_addr1", bus.addr, 32'd16 + 32'(r * 4));
      chk("lat_req", {31'd0, bus.req}, 32'd1);
      bus.ready = 1'b1;
      tick(); chk_id("lat_v2", 32'd20 + 32'(r * 4), 32'hE000_0010 + 32'(r * 4));
    end

    // advance to PC=0x20, then branch while waiting on it
    tick(); chk_id("adv0", 32'd28, 32'hE000_0018);
    tick(); chk_id("adv1", 32'd32, 32'hE000_001C);
    bus.ready = 1'b0;
    tick(); chk("wait20_addr", bus.addr, 32'h20);
    branch_taken = 1'b1; branch_addr = 32'h100;
    tick(); chk("br_valid", {31'd0, id_valid}, 32'd0);
    chk("drain_req", {31'd0, bus.req}, 32'd0);
    branch_taken = 1'b0;
    tick(); chk("drain_req1", {31'd0, bus.req}, 32'd0);
    bus.ready = 1'b1;
    tick(); chk("drain_valid", {31'd0, id_valid}, 32'd0);
    chk("post_drain_req", {31'd0, bus.req}, 32'd1);
    chk("post_drain_addr", bus.addr, 32'h100);
    tick(); chk_id("br_first", 32'h104, 32'hE000_0100);

    // branch + freeze + ready together: branch wins
    branch_taken = 1'b1; freeze = 1'b1; branch_addr = 32'h200;
    tick(); chk("sim_valid", {31'd0, id_valid}, 32'd0);
    chk("sim_req", {31'd0, bus.req}, 32'd1);
    chk("sim_addr", bus.addr, 32'h200);
    branch_taken = 1'b0; freeze = 1'b0;
    tick(); chk_id("sim_first", 32'h204, 32'hE000_0200);

    // freeze without ready: IF/ID untouched
    freeze = 1'b1; bus.ready = 1'b0;
    tick(); chk_id("frz_nordy", 32'h204, 32'hE000_0200);
    chk("frz_nordy_addr", bus.addr, 32'h204);
    freeze = 1'b0; bus.ready = 1'b1;

    // PC wrap
    branch_taken = 1'b1; branch_addr = 32'hFFFF_FFFC;
    tick(); chk("wrap_valid", {31'd0, id_valid}, 32'd0);
    chk("wrap_addr", bus.addr, 32'hFFFF_FFFC);
    branch_taken = 1'b0;
    tick(); chk_id("wrap0", 32'h0, 32'h1FFF_FFFC);
    chk("wrap_next_addr", bus.addr, 32'h0);
    tick(); chk_id("wrap1", 32'h4, 32'hE000_0000);

    // reset mid-transaction
    bus.ready = 1'b0; rst = 1'b1;
    tick(); chk("mrst_valid", {31'd0, id_valid}, 32'd0);
    chk("mrst_addr", bus.addr, 32'h0);
    chk("mrst_req", {31'd0, bus.req}, 32'd1);
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the ARM pipeline: owns the PC, issues requests to a variable-latency instruction memory, and loads the IF/ID pipeline register. It consumes the hazard unit's `hazard_detected` as `freeze` and the EXE stage's branch redirect. It keeps at most one fetched-but-unconsumed instruction in a one-entry skid register.

## Interface
- `ADDR_W`, 32, PC and memory address width
- `INSTR_W`, 32, instruction width
- `RESET_PC`, 0, PC value after reset
- `clk`  in  1  clock, all state updates on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `freeze`  in  1  stall request from the hazard unit; holds PC and IF/ID
- `branch_taken`  in  1  redirect request from EXE; flushes IF/ID
- `branch_addr`  in  ADDR_W  redirect target, sampled when `branch_taken`=1
- `imem_req`  out  1  memory request valid
- `imem_addr`  out  ADDR_W  request address, always equal to PC
- `imem_rdata`  in  INSTR_W  instruction data, valid when `imem_ready`=1
- `imem_ready`  in  1  one-cycle completion pulse; may be asserted in the same cycle as `imem_req`
- `id_pc`  out  ADDR_W  PC+4 of the instruction in IF/ID
- `id_instr`  out  INSTR_W  instruction in IF/ID
- `id_valid`  out  1  IF/ID holds a real instruction (0 = bubble)

## Operation
- FSM with three states: `S_REQ`, `S_HOLD`, `S_DRAIN`.
- **Reset:** state `S_REQ`, PC=`RESET_PC`, `id_pc`=0, `id_instr`=0, `id_valid`=0, skid empty. `imem_req`=1 in the first cycle after reset.
- **Request protocol:** `imem_req`=1 only in `S_REQ`. `imem_addr` stays constant until `imem_ready`. `imem_ready` is ignored outside `S_REQ` and `S_DRAIN`.
- **`S_REQ`, with `branch_taken`=0:**
  - ready=1, freeze=0: load IF/ID with {PC+4, rdata, valid=1}; PC += 4.
  - ready=1, freeze=1: capture rdata into skid; IF/ID unchanged; go to `S_HOLD`.
  - ready=0, freeze=0: `id_valid` <= 0 (bubble); `id_pc`/`id_instr` unchanged.
  - ready=0, freeze=1: IF/ID unchanged.
- **`S_HOLD`:** `imem_req`=0. While freeze=1, stay. When freeze=0: load IF/ID from skid, PC += 4, go to `S_REQ`.
- **Branch has priority over freeze in every state.**
  - PC <= `branch_addr`, `id_valid` <= 0, skid emptied.
  - Next state is `S_DRAIN` if in `S_REQ` with ready=0 (a request is outstanding); otherwise `S_REQ`.
  - If ready=1 in the branch cycle, the returned data is discarded.
- **`S_DRAIN`:** `imem_req`=0. Wait for `imem_ready`, discard the data, go to `S_REQ`. A further `branch_taken` while draining only updates PC.
- **Arithmetic:** PC+4 wraps modulo 2^ADDR_W. `branch_addr` is used unmodified; no alignment check.
- **`rst` mid-transaction:** overrides everything; the outstanding memory response is not drained.

## Timing
- IF/ID outputs are registered. An instruction appears one cycle after the `imem_ready` cycle.
- With a zero-wait memory (ready in the same cycle as req) and no stalls, throughput is one instruction per cycle.
- With memory latency N cycles, there are N−1 bubbles per instruction.
- Branch: `imem_addr`=`branch_addr` in the cycle after `branch_taken`, or after the drain completes. IF/ID is invalid in the cycle after `branch_taken`.
- Freeze release from `S_HOLD`: the skid instruction is in IF/ID in the cycle after freeze falls, and a new request issues that same cycle.
- `imem_req` and `imem_addr` are decoded from registered state and PC only; no combinational path from `freeze` or `branch_taken`.

## Structure
- Shared package `fetch_pkg`: FSM state enum, `RESET_PC` default, `PC_INC`=4.
- One sub-module, `if_id_reg`: {pc, instr, valid} register with load, bubble and flush controls. The FSM and PC logic stay in `fetch_stage`.

## Test plan
- **Reset and stream:** zero-wait memory returning addr^32'hE000_0000, `rst` for 2 cycles → `id_valid`=0 during reset; then `id_pc`=4, 8, 12 on consecutive cycles, each with the matching instruction.
- **Freeze with capture:** freeze high for 3 cycles while a ready arrives at PC=8 → IF/ID holds PC+4=8 (the previous instruction) throughout; after release `id_pc`=12 with instr(8); no address skipped or repeated.
- **Latency-3 memory:** req at 0 → ready on the third cycle; `id_valid` pattern 0,0,1 repeating; `imem_addr` stable while waiting.
- **Branch with request outstanding:** `branch_taken` with `branch_addr`=0x100 while waiting on 0x20 → `id_valid`=0; the 0x20 response is discarded in `S_DRAIN`; next `imem_addr`=0x100; next `id_pc`=0x104.
- **Simultaneous events:** branch_taken=1, freeze=1 and ready=1 in the same cycle → branch wins: flush, no `S_HOLD`, next `imem_addr`=`branch_addr`.
- **PC wrap:** `branch_addr`=0xFFFF_FFFC → next fetch at 0x0000_0000; `id_pc`=0x0000_0000 for the first instruction.
